// File: rtl/rstmgr_crash_capture_ctrl.sv
// Arms on a software write and fires a one-cycle crash-dump capture strobe on the first new reset request.
// Latency: a rising request in cycle N gives dump_capture_o in cycle N+1+CaptureDelay; en_o drops from N+1.
// No backpressure: the slot store must accept the strobe; later requests are ignored until software re-arms.
module rstmgr_crash_capture_ctrl #(
   parameter int NumSrc       = 4,
   parameter int CaptureDelay = 0,
   parameter int CntWidth     = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumSrc-1:0]   src_req_i,
   input  logic                en_we_i,
   input  logic                en_wdata_i,
   input  logic                cnt_clr_i,
   output logic                en_o,
   output logic                busy_o,
   output logic                dump_capture_o,
   output logic [NumSrc-1:0]   cause_o,
   output logic [CntWidth-1:0] capture_cnt_o
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StDelay = 2'd2,
      StCapt  = 2'd3
   } state_e;

   // The delay counter is loaded with CaptureDelay-1 so that DELAY lasts exactly CaptureDelay cycles.
   localparam logic [7:0]          DlyInit = (CaptureDelay > 0) ? 8'(CaptureDelay - 1) : 8'd0;
   localparam logic [CntWidth-1:0] CntMax  = '1;

   state_e                state_q, state_d;
   logic [NumSrc-1:0]     src_q, src_d;
   logic [NumSrc-1:0]     cause_q, cause_d;
   logic [7:0]            dly_q, dly_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic                  en_q, en_d;
   logic                  busy_q, busy_d;
   logic                  capt_q, capt_d;
   logic [NumSrc-1:0]     rise;
   logic                  trig;

   // Next-state logic: edge detect, arm/trigger/delay sequencing, cause latch and saturating counter.
   always_comb begin
      rise    = src_req_i & ~src_q;
      trig    = |rise;
      src_d   = src_req_i;
      state_d = state_q;
      dly_d   = dly_q;
      // A clear applies first; a capture in the same cycle then increments from zero,
      // and a trigger in the same cycle overwrites the cleared cause.
      cnt_d   = cnt_clr_i ? '0 : cnt_q;
      cause_d = cnt_clr_i ? '0 : cause_q;

      case (state_q)
         StIdle: begin
            if (en_we_i && en_wdata_i) begin
               state_d = StArmed;
            end
         end
         StArmed: begin
            // A trigger wins over a disarm write in the same cycle so no crash is lost.
            if (trig) begin
               cause_d = rise;
               if (CaptureDelay > 0) begin
                  state_d = StDelay;
                  dly_d   = DlyInit;
               end else begin
                  state_d = StCapt;
               end
            end else if (en_we_i && !en_wdata_i) begin
               state_d = StIdle;
            end
         end
         StDelay: begin
            if (dly_q == 8'd0) begin
               state_d = StCapt;
            end else begin
               dly_d = dly_q - 8'd1;
            end
         end
         StCapt: begin
            // Disarm after every capture so the first crash dump is preserved.
            state_d = StIdle;
            if (cnt_d != CntMax) begin
               cnt_d = cnt_d + CntWidth'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      en_d   = (state_d == StArmed);
      busy_d = (state_d == StDelay) || (state_d == StCapt);
      capt_d = (state_d == StCapt);
   end

   // State, history and registered status outputs; async reset returns everything to IDLE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         src_q   <= '0;
         cause_q <= '0;
         dly_q   <= 8'd0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         capt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         cause_q <= cause_d;
         dly_q   <= dly_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         capt_q  <= capt_d;
      end
   end

   assign en_o           = en_q;
   assign busy_o         = busy_q;
   assign dump_capture_o = capt_q;
   assign cause_o        = cause_q;
   assign capture_cnt_o  = cnt_q;

endmodule

// File: tb/tb_rstmgr_crash_capture_ctrl.sv
// Drives three controllers (capture delays 0, 3 and 5; counter widths 2, 8 and 4) with the same stimulus.
// Expected strobes are queued by a cycle-level reference model; a negedge monitor pops and compares them.
// Status outputs (en, busy, cause, count) are compared every cycle against the model.
module tb_rstmgr_crash_capture_ctrl;

   localparam int NI = 3;
   localparam int DLY  [NI] = '{0, 3, 5};
   localparam int MAXC [NI] = '{3, 255, 15};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] src;
   logic       we, wd, clr;

   logic       en_w   [NI];
   logic       busy_w [NI];
   logic       cap_w  [NI];
   logic [3:0] cause_w[NI];
   logic [1:0] cnt0;
   logic [7:0] cnt1;
   logic [3:0] cnt2;
   int         cnt_w  [NI];

   always #5 clk = ~clk;

   rstmgr_crash_capture_ctrl #(.NumSrc(4), .CaptureDelay(0), .CntWidth(2)) u_d0 (
      .clk_i(clk), .rst_ni(rst_n), .src_req_i(src), .en_we_i(we), .en_wdata_i(wd),
      .cnt_clr_i(clr), .en_o(en_w[0]), .busy_o(busy_w[0]), .dump_capture_o(cap_w[0]),
      .cause_o(cause_w[0]), .capture_cnt_o(cnt0));
   rstmgr_crash_capture_ctrl #(.NumSrc(4), .CaptureDelay(3), .CntWidth(8)) u_d3 (
      .clk_i(clk), .rst_ni(rst_n), .src_req_i(src), .en_we_i(we), .en_wdata_i(wd),
      .cnt_clr_i(clr), .en_o(en_w[1]), .busy_o(busy_w[1]), .dump_capture_o(cap_w[1]),
      .cause_o(cause_w[1]), .capture_cnt_o(cnt1));
   rstmgr_crash_capture_ctrl #(.NumSrc(4), .CaptureDelay(5), .CntWidth(4)) u_d5 (
      .clk_i(clk), .rst_ni(rst_n), .src_req_i(src), .en_we_i(we), .en_wdata_i(wd),
      .cnt_clr_i(clr), .en_o(en_w[2]), .busy_o(busy_w[2]), .dump_capture_o(cap_w[2]),
      .cause_o(cause_w[2]), .capture_cnt_o(cnt2));

   always_comb begin
      cnt_w[0] = int'(cnt0);
      cnt_w[1] = int'(cnt1);
      cnt_w[2] = int'(cnt2);
   end

   // Reference model: an armed flag plus the absolute cycle at which a capture is due.
   typedef struct {
      int         inst;
      int         cyc;
      logic [3:0] cause;
   } exp_t;

   exp_t       sbq[$];
   bit         armed_m  [NI];
   int         capt_at_m[NI];
   logic [3:0] cause_m  [NI];
   int         cnt_m    [NI];
   logic [3:0] prev_m;
   int         cyc;
   int         asserts = 0;
   int         errs    = 0;
   bit         mon_on  = 1'b0;

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         armed_m[i]   = 1'b0;
         capt_at_m[i] = -1;
         cause_m[i]   = '0;
         cnt_m[i]     = 0;
      end
      prev_m = '0;
      sbq.delete();
   endtask

   // Applies the inputs sampled at the end of cycle 'cyc' to the model.
   task automatic model_step();
      logic [3:0] rise;
      rise = src & ~prev_m;
      for (int i = 0; i < NI; i++) begin
         bit strobe;
         bit idle;
         int base;
         strobe = (capt_at_m[i] == cyc);
         idle   = !armed_m[i] && (capt_at_m[i] < 0);
         base   = clr ? 0 : cnt_m[i];
         if (strobe) cnt_m[i] = (base >= MAXC[i]) ? MAXC[i] : base + 1;
         else        cnt_m[i] = base;
         if (armed_m[i] && rise != 4'b0) begin
            cause_m[i] = rise;
         end else if (clr) begin
            cause_m[i] = '0;
            if (capt_at_m[i] > cyc) begin
               foreach (sbq[k]) if (sbq[k].inst == i) sbq[k].cause = '0;
            end
         end
         if (strobe) capt_at_m[i] = -1;
         if (armed_m[i]) begin
            if (rise != 4'b0) begin
               armed_m[i]   = 1'b0;
               capt_at_m[i] = cyc + 1 + DLY[i];
               sbq.push_back('{inst: i, cyc: capt_at_m[i], cause: rise});
            end else if (we && !wd) begin
               armed_m[i] = 1'b0;
            end
         end else if (idle && we && wd) begin
            armed_m[i] = 1'b1;
         end
      end
      prev_m = src;
   endtask

   task automatic chk(input string name, input int inst, input longint act, input longint exp);
      asserts++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, inst, cyc, act, exp);
      end
   endtask

   // Monitor: pops queued captures when a strobe appears, flags missing/unexpected strobes, checks status.
   always @(negedge clk) begin
      if (mon_on) begin
         for (int i = 0; i < NI; i++) begin
            int idx;
            int k;
            idx = -1;
            if (cap_w[i]) begin
               foreach (sbq[j]) if (idx < 0 && sbq[j].inst == i) idx = j;
               if (idx < 0) begin
                  asserts++;
                  errs++;
                  $display("FAIL strobe_unexpected inst=%0d cyc=%0d got=1 expected=0", i, cyc);
               end else begin
                  chk("strobe_cycle", i, cyc, sbq[idx].cyc);
                  chk("strobe_cause", i, cause_w[i], sbq[idx].cause);
                  sbq.delete(idx);
               end
            end
            k = 0;
            while (k < sbq.size()) begin
               if (sbq[k].inst == i && sbq[k].cyc <= cyc) begin
                  asserts++;
                  errs++;
                  $display("FAIL strobe_missing inst=%0d cyc=%0d got=0 expected=1 at cyc %0d",
                           i, cyc, sbq[k].cyc);
                  sbq.delete(k);
               end else begin
                  k++;
               end
            end
            chk("en", i, en_w[i], armed_m[i]);
            chk("busy", i, busy_w[i], capt_at_m[i] >= 0);
            chk("cause", i, cause_w[i], cause_m[i]);
            chk("count", i, cnt_w[i], cnt_m[i]);
         end
      end
   end

   task automatic step(input logic [3:0] s, input bit w, input bit d, input bit c);
      src = s; we = w; wd = d; clr = c;
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(src, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      src = '0; we = 1'b0; wd = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) begin
         @(posedge clk);
         cyc++;
      end
      #1 rst_n = 1'b1;
   endtask

   initial begin
      cyc = 0;
      do_reset();
      mon_on = 1'b1;

      // Never armed: a held request must not capture.
      step(4'b0001, 0, 0, 0);
      hold(6);
      step(4'b0000, 0, 0, 0);

      // Arm, then a single source rises.
      step(4'b0000, 1, 1, 0);
      hold(2);
      step(4'b0100, 0, 0, 0);
      hold(8);
      step(4'b0000, 0, 0, 0);

      // Two sources rise together, a third rises during the delay and is ignored.
      step(4'b0000, 1, 1, 0);
      step(4'b0011, 0, 0, 0);
      step(4'b0011, 0, 0, 0);
      step(4'b1011, 0, 0, 0);
      hold(8);
      step(4'b0000, 0, 0, 0);

      // Source already high at arm time does not trigger; a later rise does.
      step(4'b0010, 0, 0, 0);
      step(4'b0010, 1, 1, 0);
      hold(4);
      step(4'b0110, 0, 0, 0);
      hold(8);
      step(4'b0000, 0, 0, 0);

      // Trigger and disarm write in the same cycle: the trigger wins.
      step(4'b0000, 1, 1, 0);
      step(4'b1000, 1, 0, 0);
      hold(8);
      step(4'b0000, 0, 0, 0);

      // Clears landing on the capture cycle of each delay variant.
      step(4'b0000, 1, 1, 0);
      step(4'b0100, 0, 0, 0);
      step(4'b0100, 0, 0, 1);
      step(4'b0100, 0, 0, 0);
      step(4'b0100, 0, 0, 0);
      step(4'b0100, 0, 0, 1);
      step(4'b0100, 0, 0, 0);
      step(4'b0100, 0, 0, 1);
      hold(3);
      step(4'b0000, 0, 0, 0);

      // Five captures in a row: the 2-bit counter saturates.
      for (int n = 0; n < 5; n++) begin
         step(4'b0000, 1, 1, 0);
         step(4'b0001, 0, 0, 0);
         hold(8);
         step(4'b0000, 0, 0, 0);
      end

      // Reset asserted while the delayed variants are mid-delay: no late strobe.
      step(4'b0000, 1, 1, 0);
      step(4'b0001, 0, 0, 0);
      hold(2);
      do_reset();
      hold(12);

      // Randomized traffic with occasional arm/disarm writes, clears and resets.
      for (int n = 0; n < 600; n++) begin
         if (n % 200 == 199) do_reset();
         step(4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
              1'($urandom_range(0, 3) != 0), $urandom_range(0, 19) == 0);
      end
      step(4'b0000, 0, 0, 0);
      hold(10);

      mon_on = 1'b0;
      asserts++;
      if (sbq.size() != 0) begin
         errs++;
         $display("FAIL pending_captures got=%0d expected=0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, errs);
      $finish;
   end

endmodule
